// File: rtl/dpc_pkg.sv
// Shared definitions for the dekatron program-counter fetch path.
// Holds the IP geometry (digit count, digit width), instruction width, the
// bootloader prefix that forms the reset vector, the fetch-state enum, and a
// per-digit BCD step helper used by bcd_updown.
package dpc_pkg;

  localparam int unsigned IP_DEKATRON_NUM = 6;
  localparam int unsigned DEKATRON_WIDTH  = 4;
  localparam int unsigned INSN_WIDTH      = 4;
  localparam int unsigned IP_WIDTH        = IP_DEKATRON_NUM * DEKATRON_WIDTH;

  localparam logic [15:0] BOOTLOADER_PREFIX = 16'h9999;

  typedef logic [IP_WIDTH-1:0]       ip_t;
  typedef logic [DEKATRON_WIDTH-1:0] digit_t;
  typedef logic [INSN_WIDTH-1:0]     insn_t;

  localparam digit_t DIGIT_MAX        = digit_t'(9);
  localparam ip_t    RESET_IP_DEFAULT = {BOOTLOADER_PREFIX, {(IP_WIDTH - 16){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StValid
  } fetch_state_e;

  // One BCD digit stepped by +1 (dec=0) or -1 (dec=1) when cin is set.
  function automatic digit_t step_digit(digit_t d, logic dec, logic cin);
    if (!cin) begin
      return d;
    end
    if (dec) begin
      return (d == digit_t'(0)) ? DIGIT_MAX : d - 1'b1;
    end
    return (d >= DIGIT_MAX) ? digit_t'(0) : d + 1'b1;
  endfunction

endpackage

// File: rtl/bcd_updown.sv
// Combinational chained-digit BCD +/-1.
// Ports:
//   value  - BCD input vector
//   dec    - 0 = increment, 1 = decrement
//   result - value +/- 1 with per-digit carry/borrow
//   wrap   - carry/borrow out of the top digit (999999+1 or 000000-1)
//   valid  - every digit of value is 0..9
module bcd_updown
  import dpc_pkg::*;
(
  input  logic [IP_WIDTH-1:0] value,
  input  logic                dec,
  output logic [IP_WIDTH-1:0] result,
  output logic                wrap,
  output logic                valid
);

  logic carry;

  always_comb begin
    carry  = 1'b1;
    valid  = 1'b1;
    result = '0;
    for (int i = 0; i < IP_DEKATRON_NUM; i++) begin
      if (value[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] > DIGIT_MAX) begin
        valid = 1'b0;
      end
      result[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] =
          step_digit(value[i*DEKATRON_WIDTH +: DEKATRON_WIDTH], dec, carry);
      carry = carry && (dec ? (value[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] == digit_t'(0))
                            : (value[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] == DIGIT_MAX));
    end
    wrap = carry;
  end

endmodule

// File: rtl/ip_fetch_unit.sv
// Instruction-fetch stage in front of IpMemory.
// Owns the BCD instruction pointer, issues one-cycle MemRequest pulses, waits
// for MemReady (ignoring it in the first wait cycle), and hands the captured
// instruction to the decoder over InsnValid/InsnReady. On accept the IP steps
// +1 or -1 per Dir. JumpLoad loads an absolute BCD target; during an in-flight
// fetch the target is held pending and the returning data is dropped.
// Geometry (IP_DEKATRON_NUM, DEKATRON_WIDTH, INSN_WIDTH) comes from dpc_pkg.
// Optional feature macro IP_BREAKPOINT_EN adds BpEnable/BpAddr/BpHit: fetch
// halts before requesting BpAddr and resumes on a Run low->high edge.
// Ports:
//   Clk, Rst_n            clock, async active-low reset
//   Run, Dir              fetch enable level, step direction (1 = -1)
//   JumpLoad, JumpAddr    jump pulse and BCD target
//   MemRequest/MemAddress request pulse and address (always the IP)
//   MemReady/MemInsn      memory response
//   InsnValid/InsnReady   decoder handshake; Insn, InsnIp are its payload
//   IpWrap, AddrError     one-cycle event pulses
module ip_fetch_unit
  import dpc_pkg::*;
#(
  parameter ip_t RESET_IP = RESET_IP_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Run,
  input  logic                  Dir,
  input  logic                  JumpLoad,
  input  logic [IP_WIDTH-1:0]   JumpAddr,
  output logic                  MemRequest,
  output logic [IP_WIDTH-1:0]   MemAddress,
  input  logic                  MemReady,
  input  logic [INSN_WIDTH-1:0] MemInsn,
  output logic                  InsnValid,
  input  logic                  InsnReady,
  output logic [INSN_WIDTH-1:0] Insn,
  output logic [IP_WIDTH-1:0]   InsnIp,
  output logic                  IpWrap,
  output logic                  AddrError
`ifdef IP_BREAKPOINT_EN
  ,
  input  logic                  BpEnable,
  input  logic [IP_WIDTH-1:0]   BpAddr,
  output logic                  BpHit
`endif
);

  fetch_state_e state_q;
  ip_t          ip_q, jump_tgt_q, insn_ip_q;
  insn_t        insn_q;
  logic         mem_req_q, insn_valid_q, ip_wrap_q, addr_err_q;
  logic         first_wait_q, jump_pend_q, bp_hit_q, run_q;

  ip_t  step_ip, tgt_ip;
  logic step_wrap, jump_ok, jump_now;
  logic dispatch, wrap_now, bp_tgt;

  logic unused_step_valid, unused_jump_wrap;
  ip_t  unused_jump_result;

  bcd_updown u_step (
    .value  (ip_q),
    .dec    (Dir),
    .result (step_ip),
    .wrap   (step_wrap),
    .valid  (unused_step_valid)
  );

  // Second instance only for its digit-validity output.
  bcd_updown u_jump_check (
    .value  (JumpAddr),
    .dec    (1'b0),
    .result (unused_jump_result),
    .wrap   (unused_jump_wrap),
    .valid  (jump_ok)
  );

  assign jump_now = JumpLoad && jump_ok;

  // dispatch: this cycle ends the current state and loads tgt_ip into the IP;
  // the sequential block then decides REQ, IDLE, or breakpoint halt.
  always_comb begin
    dispatch = 1'b0;
    wrap_now = 1'b0;
    tgt_ip   = ip_q;
    unique case (state_q)
      StIdle: begin
        if (jump_now) begin
          dispatch = 1'b1;
          tgt_ip   = JumpAddr;
        end else if (Run && !bp_hit_q) begin
          dispatch = 1'b1;
        end
      end
      StReq: begin
      end
      StWait: begin
        // A pending (or same-cycle) jump discards the returning data.
        if (!first_wait_q && MemReady && (jump_pend_q || jump_now)) begin
          dispatch = 1'b1;
          tgt_ip   = jump_now ? JumpAddr : jump_tgt_q;
        end
      end
      StValid: begin
        if (jump_now) begin
          dispatch = 1'b1;
          tgt_ip   = JumpAddr;
        end else if (InsnReady) begin
          dispatch = 1'b1;
          tgt_ip   = step_ip;
          wrap_now = step_wrap;
        end
      end
    endcase
  end

`ifdef IP_BREAKPOINT_EN
  assign bp_tgt = BpEnable && (tgt_ip == BpAddr);
  assign BpHit  = bp_hit_q;
`else
  assign bp_tgt = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= StIdle;
      ip_q         <= RESET_IP;
      jump_tgt_q   <= '0;
      insn_ip_q    <= '0;
      insn_q       <= '0;
      mem_req_q    <= 1'b0;
      insn_valid_q <= 1'b0;
      ip_wrap_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      first_wait_q <= 1'b0;
      jump_pend_q  <= 1'b0;
      bp_hit_q     <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      mem_req_q  <= 1'b0;
      ip_wrap_q  <= wrap_now;
      addr_err_q <= JumpLoad && !jump_ok;
      run_q      <= Run;
      if (dispatch) begin
        ip_q         <= tgt_ip;
        insn_valid_q <= 1'b0;
        jump_pend_q  <= 1'b0;
        first_wait_q <= 1'b0;
        if (!Run) begin
          state_q <= StIdle;
        end else if (bp_tgt) begin
          state_q  <= StIdle;
          bp_hit_q <= 1'b1;
        end else begin
          state_q   <= StReq;
          mem_req_q <= 1'b1;
          bp_hit_q  <= 1'b0;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            // Resume from a breakpoint halt without re-checking the address.
            if (bp_hit_q && Run && !run_q) begin
              state_q   <= StReq;
              mem_req_q <= 1'b1;
              bp_hit_q  <= 1'b0;
            end
          end
          StReq: begin
            state_q      <= StWait;
            first_wait_q <= 1'b1;
            if (jump_now) begin
              jump_pend_q <= 1'b1;
              jump_tgt_q  <= JumpAddr;
            end
          end
          StWait: begin
            first_wait_q <= 1'b0;
            if (jump_now) begin
              jump_pend_q <= 1'b1;
              jump_tgt_q  <= JumpAddr;
            end
            if (!first_wait_q && MemReady) begin
              insn_q       <= MemInsn;
              insn_ip_q    <= ip_q;
              insn_valid_q <= 1'b1;
              state_q      <= StValid;
            end
          end
          StValid: begin
          end
        endcase
      end
    end
  end

  assign MemRequest = mem_req_q;
  assign MemAddress = ip_q;
  assign InsnValid  = insn_valid_q;
  assign Insn       = insn_q;
  assign InsnIp     = insn_ip_q;
  assign IpWrap     = ip_wrap_q;
  assign AddrError  = addr_err_q;

endmodule

// File: tb/tb_ip_fetch_unit.sv
// Bench for ip_fetch_unit: behavioural IpMemory, expected-fetch scoreboard,
// a table of step vectors and hand-written jump / stall / reset sequences.
module tb_ip_fetch_unit;
  import dpc_pkg::*;

  logic  Clk;
  logic  Rst_n, Run, Dir, JumpLoad, InsnReady;
  ip_t   JumpAddr, MemAddress, InsnIp;
  insn_t Insn;
  logic  MemRequest, InsnValid, IpWrap, AddrError;
  logic  MemReady = 1'b0;
  insn_t MemInsn  = '0;
`ifdef IP_BREAKPOINT_EN
  logic  BpEnable, BpHit;
  ip_t   BpAddr;
`endif

  ip_fetch_unit u_dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Run        (Run),
    .Dir        (Dir),
    .JumpLoad   (JumpLoad),
    .JumpAddr   (JumpAddr),
    .MemRequest (MemRequest),
    .MemAddress (MemAddress),
    .MemReady   (MemReady),
    .MemInsn    (MemInsn),
    .InsnValid  (InsnValid),
    .InsnReady  (InsnReady),
    .Insn       (Insn),
    .InsnIp     (InsnIp),
    .IpWrap     (IpWrap),
    .AddrError  (AddrError)
`ifdef IP_BREAKPOINT_EN
    ,
    .BpEnable   (BpEnable),
    .BpAddr     (BpAddr),
    .BpHit      (BpHit)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  // Memory contents: XOR of the address digits, offset by 3.
  function automatic insn_t mem_of(input ip_t a);
    insn_t r;
    r = 4'h3;
    for (int i = 0; i < IP_DEKATRON_NUM; i++) r ^= a[i*4 +: 4];
    return r;
  endfunction

  // IpMemory model and event monitors, all evaluated on the falling edge.
  logic pending = 1'b0;
  logic prev_req = 1'b0;
  int   wait_n = 0, extra_lat = 0;
  ip_t  addr_l = '0, last_req = '0;
  int   req_cnt = 0, wrap_cnt = 0, aerr_cnt = 0, req_overlap = 0;

  always @(negedge Clk) begin
    MemReady = 1'b0;
    if (!Rst_n) begin
      pending = 1'b0;
    end else if (MemRequest) begin
      if (pending) req_overlap++;
      pending  = 1'b1;
      wait_n   = 1 + extra_lat;
      addr_l   = MemAddress;
      last_req = MemAddress;
      req_cnt++;
    end else if (pending) begin
      if (wait_n == 0) begin
        MemReady = 1'b1;
        MemInsn  = mem_of(addr_l);
        pending  = 1'b0;
      end else begin
        wait_n--;
      end
    end
    if (IpWrap) wrap_cnt++;
    if (AddrError) aerr_cnt++;
    if (MemRequest && prev_req) req_overlap++;
    prev_req = MemRequest;
  end

  typedef struct packed {
    insn_t insn;
    ip_t   ip;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    ip_t  start;
    logic dir;
    ip_t  next;
    int   wraps;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_fetch(input ip_t ip);
    exp_t e;
    e.insn = mem_of(ip);
    e.ip   = ip;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!InsnValid && n < 40) begin
      tick();
      n++;
    end
    if (!InsnValid) begin
      total++;
      bad++;
      $display("FAIL %s: InsnValid timeout got 0 expected 1", name);
    end else if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected instruction got ip %h expected none", name, InsnIp);
    end else begin
      e = exp_q.pop_front();
      check({name, " insn"}, 32'(Insn), 32'(e.insn));
      check({name, " insn_ip"}, 32'(InsnIp), 32'(e.ip));
      check({name, " req_addr"}, 32'(last_req), 32'(e.ip));
    end
  endtask

  task automatic accept(input logic d);
    Dir       = d;
    InsnReady = 1'b1;
    tick();
    InsnReady = 1'b0;
    Dir       = 1'b0;
  endtask

  task automatic jump(input ip_t a);
    JumpLoad = 1'b1;
    JumpAddr = a;
    tick();
    JumpLoad = 1'b0;
  endtask

  int r0, a0, w0;

  initial begin
    vecs[0] = '{24'h000009, 1'b0, 24'h000010, 0};
    vecs[1] = '{24'h999999, 1'b0, 24'h000000, 1};
    vecs[2] = '{24'h000100, 1'b1, 24'h000099, 0};
    vecs[3] = '{24'h000000, 1'b1, 24'h999999, 1};
    vecs[4] = '{24'h099999, 1'b0, 24'h100000, 0};
    vecs[5] = '{24'h010000, 1'b1, 24'h009999, 0};

    Rst_n = 1'b0; Run = 1'b0; Dir = 1'b0; JumpLoad = 1'b0; InsnReady = 1'b0;
    JumpAddr = '0;
`ifdef IP_BREAKPOINT_EN
    BpEnable = 1'b0; BpAddr = '0;
`endif
    tick();
    tick();
    check("reset MemRequest", 32'(MemRequest), 32'd0);
    check("reset InsnValid", 32'(InsnValid), 32'd0);
    check("reset Insn", 32'(Insn), 32'd0);
    check("reset InsnIp", 32'(InsnIp), 32'd0);
    check("reset IpWrap", 32'(IpWrap), 32'd0);
    check("reset AddrError", 32'(AddrError), 32'd0);
    check("reset MemAddress", 32'(MemAddress), 32'h999900);

    // Boot fetch: request in cycle 1, instruction in cycle 4.
    Rst_n = 1'b1;
    Run   = 1'b1;
    expect_fetch(24'h999900);
    tick();
    check("boot req c1", 32'(MemRequest), 32'd1);
    check("boot addr c1", 32'(MemAddress), 32'h999900);
    tick();
    check("boot req c2", 32'(MemRequest), 32'd0);
    tick();
    check("boot valid c3", 32'(InsnValid), 32'd0);
    tick();
    check("boot valid c4", 32'(InsnValid), 32'd1);
    check("boot insn c4", 32'(Insn), 32'h3);
    wait_valid("boot");

    // Decoder stall: payload held, no new requests.
    r0 = req_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall hold", {3'd0, InsnValid, Insn, InsnIp}, {3'd0, 1'b1, 4'h3, 24'h999900});
    end
    check("stall no req", 32'(req_cnt), 32'(r0));

    // Invalid jump target.
    a0 = aerr_cnt;
    jump(24'h00A000);
    check("bad jump pulse", 32'(aerr_cnt), 32'(a0 + 1));
    tick();
    check("bad jump single", 32'(aerr_cnt), 32'(a0 + 1));
    check("bad jump ip", 32'(MemAddress), 32'h999900);
    check("bad jump valid", 32'(InsnValid), 32'd1);
    check("bad jump no req", 32'(req_cnt), 32'(r0));

    // Step vectors: jump to start, accept with Dir, check next fetch and wrap.
    for (int i = 0; i < 6; i++) begin
      expect_fetch(vecs[i].start);
      jump(vecs[i].start);
      wait_valid("vec jump");
      w0 = wrap_cnt;
      expect_fetch(vecs[i].next);
      accept(vecs[i].dir);
      wait_valid("vec step");
      check("vec wrap", 32'(wrap_cnt - w0), 32'(vecs[i].wraps));
    end

    // Jump in the first WAIT cycle: in-flight data dropped.
    accept(1'b0);
    tick();
    expect_fetch(24'h001234);
    jump(24'h001234);
    check("wait jump no valid", 32'(InsnValid), 32'd0);
    wait_valid("wait jump");

    // Second jump overwrites the pending target; slower memory.
    extra_lat = 2;
    r0 = req_cnt;
    accept(1'b0);
    tick();
    jump(24'h002222);
    jump(24'h004321);
    expect_fetch(24'h004321);
    wait_valid("overwrite");
    check("overwrite reqs", 32'(req_cnt), 32'(r0 + 2));
    extra_lat = 0;

    // Run low: accept completes, then no fetch until Run returns.
    Run = 1'b0;
    accept(1'b0);
    r0 = req_cnt;
    repeat (5) tick();
    check("run low no req", 32'(req_cnt), 32'(r0));
    check("run low ip", 32'(MemAddress), 32'h004322);
    check("run low valid", 32'(InsnValid), 32'd0);
    expect_fetch(24'h004322);
    Run = 1'b1;
    wait_valid("run resume");

`ifdef IP_BREAKPOINT_EN
    BpAddr   = 24'h000003;
    BpEnable = 1'b1;
    expect_fetch(24'h000000);
    jump(24'h000000);
    wait_valid("bp 0");
    for (int k = 1; k < 3; k++) begin
      expect_fetch(ip_t'(k));
      accept(1'b0);
      wait_valid("bp step");
    end
    accept(1'b0);
    r0 = req_cnt;
    repeat (5) tick();
    check("bp hit", 32'(BpHit), 32'd1);
    check("bp no req", 32'(req_cnt), 32'(r0));
    check("bp ip", 32'(MemAddress), 32'h000003);
    Run = 1'b0;
    tick();
    Run = 1'b1;
    expect_fetch(24'h000003);
    wait_valid("bp resume");
    check("bp cleared", 32'(BpHit), 32'd0);
    BpEnable = 1'b0;
`endif

    // Reset in the middle of a fetch.
    accept(1'b0);
    tick();
    Rst_n = 1'b0;
    tick();
    check("mid reset req", 32'(MemRequest), 32'd0);
    check("mid reset valid", 32'(InsnValid), 32'd0);
    check("mid reset ip", 32'(MemAddress), 32'h999900);
    check("mid reset insn_ip", 32'(InsnIp), 32'd0);
    check("mid reset insn", 32'(Insn), 32'd0);
    Rst_n = 1'b1;
    expect_fetch(24'h999900);
    wait_valid("after reset");

    check("request protocol", 32'(req_overlap), 32'd0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
